// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter and its helpers.
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_DEFAULT_CPB = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_ctr.sv
// Loadable down-counter with a zero flag. A load takes priority; otherwise
// the count decrements and holds at zero until the next load.
module uart_baud_ctr #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load, else count down towards zero.
  // NOTE: combinational blocks assign every output a default first, so no path leaves a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  // NOTE: sequential state is written with non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-deep holding register so consecutive
// bytes leave back to back. Define UART_TX_PARITY_EN to insert an even
// parity bit between the data bits and the stop bit (8E1, 11-bit frame).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = UART_DEFAULT_CPB
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic                      tx,
  output logic                      busy_o
);

  localparam int BAUD_W = $clog2(CLOCKS_PER_BAUD);
  localparam int BIT_W  = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] hold_q, hold_d;
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic                      hold_full_q, hold_full_d;
  logic                      ready_q;
  logic                      tx_q, tx_d;
  logic                      baud_load;
  logic                      baud_zero;

  uart_baud_ctr #(
    .WIDTH (BAUD_W)
  ) u_baud (
    .clk        (clk),
    .rst        (rst),
    .load_i     (baud_load),
    .load_val_i (BAUD_RELOAD),
    .zero_o     (baud_zero)
  );

  // Handshake, holding register and frame sequencing; every state change
  // reloads the baud counter so each bit lasts exactly CLOCKS_PER_BAUD cycles.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    bit_cnt_d   = bit_cnt_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    baud_load   = 1'b0;

    // Accept only while empty; draining only happens while full, so the two
    // never compete for hold_full_d.
    if (valid_i && ready_q) begin
      hold_d      = data_i;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d     = START;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          tx_d        = 1'b0;
          baud_load   = 1'b1;
        end
      end

      START: begin
        if (baud_zero) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          baud_load = 1'b1;
        end
      end

      DATA: begin
        if (baud_zero) begin
          baud_load = 1'b1;
          // Rotate rather than shift: after eight bits the shifter holds the
          // original byte again, so its XOR still gives the parity.
          shift_d   = {shift_q[0], shift_q[UART_DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^shift_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_d      = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_zero) begin
          state_d   = STOP;
          tx_d      = 1'b1;
          baud_load = 1'b1;
        end
      end
`endif

      STOP: begin
        if (baud_zero) begin
          if (hold_full_q) begin
            state_d     = START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            baud_load   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, datapath and line registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      // NOTE: the byte registers are reset as well so an aborted frame or a held byte can never resurface.
      shift_q     <= '0;
      hold_q      <= '0;
      bit_cnt_q   <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_full_q <= hold_full_d;
      ready_q     <= !hold_full_d;
      tx_q        <= tx_d;
    end
  end

  assign ready_o = ready_q;
  assign tx      = tx_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A frame-schedule model predicts the line:
// each accepted byte gets a start edge, and tx/busy/ready at any cycle follow
// from which scheduled frame (if any) covers that cycle.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       tx;
  logic       busy_o;

  uart_tx #(
    .CLOCKS_PER_BAUD (CPB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .tx      (tx),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  typedef struct {
    int         start;
    logic [7:0] data;
  } frame_t;

  frame_t frames[$];
  int     last_end   = 0;  // edge at which the last scheduled frame ends
  int     hold_until = 0;  // holding register occupied while edge_n < hold_until

  task automatic check(string tag, logic got, logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at edge %0d", tag, got, exp, edge_n);
    end
  endtask

  function automatic logic frame_bit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic exp_tx(int t);
    foreach (frames[i])
      if (t >= frames[i].start && t < frames[i].start + FRAME_CYC)
        return frame_bit(frames[i].data, (t - frames[i].start) / CPB);
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int t);
    foreach (frames[i])
      if (t >= frames[i].start && t < frames[i].start + FRAME_CYC)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_accept(logic [7:0] b, int k);
    frame_t f;
    f.start    = (last_end > k + 1) ? last_end : k + 1;
    f.data     = b;
    frames.push_back(f);
    last_end   = f.start + FRAME_CYC;
    hold_until = f.start;
  endtask

  task automatic model_reset();
    frames.delete();
    last_end   = 0;
    hold_until = 0;
  endtask

  // One clock: update the model with the inputs seen at the edge, then check.
  task automatic tick(output bit acc);
    bit rdy;
    rdy = (edge_n >= hold_until);
    @(posedge clk);
    edge_n++;
    acc = 1'b0;
    if (rst) begin
      model_reset();
    end else if (valid_i && rdy) begin
      model_accept(data_i, edge_n);
      acc = 1'b1;
    end
    while (frames.size() > 0 && frames[0].start + FRAME_CYC <= edge_n)
      frames.delete(0);
    #1;
    check("tx", tx, exp_tx(edge_n));
    check("ready_o", ready_o, edge_n >= hold_until);
    check("busy_o", busy_o, exp_busy(edge_n));
  endtask

  task automatic idle(int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic send(logic [7:0] b);
    bit acc;
    acc     = 1'b0;
    valid_i = 1'b1;
    data_i  = b;
    for (int i = 0; i < 200 && !acc; i++) tick(acc);
    valid_i = 1'b0;
    data_i  = 8'($urandom);
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    bit acc;
    int fstart;
    rst     = 1'b1;
    valid_i = 1'b1;  // must be ignored while in reset
    data_i  = 8'h5A;
    idle(3);
    rst     = 1'b0;
    valid_i = 1'b0;
    idle(3);

    // Single frame, then line idle.
    send(8'hA5);
    idle(FRAME_CYC + 10);

    // Valid held across two bytes: second is held while the first is sent.
    send(8'h00);
    send(8'hFF);
    idle(2 * FRAME_CYC + 10);

`ifdef UART_TX_PARITY_EN
    send(8'h01);
    idle(FRAME_CYC + 5);
`endif

    // Reset in the middle of a frame with a second byte held.
    send(8'hA5);
    fstart = edge_n + 1;
    send(8'h3C);
    while (edge_n < fstart + 14) tick(acc);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    idle(FRAME_CYC + 10);

    // Random traffic: sporadic valid pulses (many while full), rare resets.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 399) == 0);
      valid_i = ($urandom_range(0, 2) == 0);
      data_i  = 8'($urandom);
      tick(acc);
    end
    rst     = 1'b0;
    valid_i = 1'b0;
    idle(2 * FRAME_CYC + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
